aes_result_scroller: RTL and testbench
======================================

Name: aes_result_scroller

Overview:
- Downstream consumer of the AES top-level result register: captures one 128-bit block (ciphertext or recovered plaintext) and presents it one byte at a time for the 7-segment path.
- Steps through all 16 bytes at a fixed dwell time, so the whole block is visible on the board, not only the last byte.
- Emits the current byte and its index. Binary-to-7-segment conversion stays downstream, in the existing converter.

Parameters:
- TICKS_PER_BYTE, 50000000, clock cycles each byte stays on the output (1 s at 50 MHz); legal range ≥1.
- CNT_W, 26, prescaler width; must satisfy 2^CNT_W ≥ TICKS_PER_BYTE.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  single-cycle strobe: capture data_in.
- data_in  input  128  block to display, [0:127]. Byte k = bits [8k +: 8], so byte 0 = MSB byte.
- hold  input  1  level: freeze dwell counter and index while high.
- ready  output  1  load will be accepted this cycle.
- busy  output  1  scrolling in progress.
- done  output  1  scroll complete.
- byte_out  output  8  currently displayed byte.
- index  output  4  number (0..15) of the byte on byte_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - State → IDLE; captured block and prescaler cleared.
  - byte_out=8'h00, index=0, busy=0, done=0, ready=1.
  - Reset mid-scroll aborts immediately; no partial completion is reported.
- States: IDLE, SHOW, DONE.
- IDLE: ready=1, busy=0, done=0, byte_out=0.
- Load acceptance: load=1 with ready=1 at edge N.
  - Block is captured; index=0; prescaler=0; state → SHOW.
  - From cycle N+1: byte_out = byte 0 and busy=1.
  - One cycle of latency from load to first byte.
- SHOW:
  - Prescaler increments every cycle while hold=0.
  - When prescaler = TICKS_PER_BYTE-1 and hold=0: prescaler wraps to 0 and index advances by 1.
  - Each byte is therefore shown exactly TICKS_PER_BYTE un-held cycles.
  - byte_out is always the captured byte at the current index, registered; no combinational path from data_in.
- Last byte (index 15) reaching terminal count:
  - State → DONE.
  - index stays 15; byte_out stays byte 15; busy=0; done=1 (level).
- DONE: ready=1. A new load restarts as from IDLE and clears done on the same edge.
- load while busy (ready=0) is ignored. data_in has no effect outside an accepted load.
- hold:
  - Freezes prescaler and index; byte_out is unchanged.
  - Release resumes from the frozen count; no cycles are lost or gained.
  - load and hold in the same cycle: load wins (capture, index=0, prescaler=0). hold then applies from the next cycle.
- TICKS_PER_BYTE=1: index advances every un-held cycle. 16 cycles in SHOW, then DONE.
- Prescaler compare is CNT_W bits wide and unsigned; no wrap beyond TICKS_PER_BYTE-1.

Optional Feature:
- Macro AES_SCROLL_LOOP_EN.
- Defined:
  - Terminal count at index 15 wraps index to 0 and stays in SHOW; DONE is unreachable.
  - done is a one-cycle pulse on each wrap edge.
  - ready=1 in SHOW, so load restarts at byte 0 at any time.
- Undefined: single-pass behaviour as specified above.

Decomposition:
- Package aes_display_pkg:
  - State encoding (IDLE=2'd0, SHOW=2'd1, DONE=2'd2).
  - NUM_BYTES=16, BYTE_W=8, INDEX_W=4.
- One sub-module, scroll_prescaler:
  - Inputs clk, reset, clear, enable.
  - Output tick at terminal count.
  - Parameterised by TICKS_PER_BYTE and CNT_W.
  - Reused later by any other display timing in the design.

Test Plan:
- Reset:
  - Assert reset=0 mid-scroll (index=7) → same cycle: index=0, byte_out=00, busy=0, done=0, ready=1.
- Basic scroll (TICKS_PER_BYTE=4):
  - Stimulus: load data_in=128'h00112233445566778899aabbccddeeff.
  - byte_out sequence 00,11,22,…,ff, each held 4 cycles; first byte at cycle N+1.
  - done=1 at cycle N+65, byte_out=ff, index=15.
- Busy reload:
  - Load a second block while index=3 → ignored; the original sequence completes unchanged.
  - Load in DONE → restarts with the new block's byte 0; done drops on the same edge.
- Hold:
  - hold=1 for 10 cycles at index 5, prescaler=2 → byte_out frozen at 55.
  - After release: exactly 2 more cycles at index 5, then index 6 (byte 66).
- Edges:
  - TICKS_PER_BYTE=1 → 16 consecutive bytes, then done.
  - load+hold in the same cycle → index=0, counting frozen until hold falls.
- AES_SCROLL_LOOP_EN defined:
  - After byte ff, index returns to 0 (byte 00).
  - One-cycle done pulse every 64 cycles (TICKS_PER_BYTE=4).
  - Load mid-loop restarts at byte 0.

Source files
------------

// File: rtl/aes_display_pkg.sv
// Shared types and constants for the AES result display path.
package aes_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } scroll_state_e;

  localparam int NUM_BYTES = 16;
  localparam int BYTE_W    = 8;
  localparam int INDEX_W   = 4;
  localparam int BLOCK_W   = NUM_BYTES * BYTE_W;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [INDEX_W-1:0] idx);
    return blk[BLOCK_W-1-BYTE_W*int'(idx) -: BYTE_W];
  endfunction

endpackage

// File: rtl/aes_result_scroller_prescaler.sv
// Dwell-time prescaler: counts enabled cycles and flags the last one of each period.
module scroll_prescaler #(
  parameter int TICKS_PER_BYTE = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS_PER_BYTE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == TERM);

  // clear outranks enable so a restart always begins a full dwell period
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (tick)   cnt_d = '0;
    else if (enable) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aes_result_scroller.sv
// Captures one 128-bit AES result and steps through its bytes at a fixed dwell.
// Define AES_SCROLL_LOOP_EN to scroll continuously instead of stopping after byte 15.
module aes_result_scroller
  import aes_display_pkg::*;
#(
  parameter int TICKS_PER_BYTE = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               hold,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [BYTE_W-1:0]  byte_out,
  output logic [INDEX_W-1:0] index
);

  scroll_state_e      state_q, state_d;
  logic [BLOCK_W-1:0] data_q;
  logic [INDEX_W-1:0] idx_q, idx_d, idx_nx;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic               load_acc, tick, last, cnt_en;

  assign load_acc = load & ready;
  assign last     = (idx_q == INDEX_W'(NUM_BYTES - 1));
  assign idx_nx   = idx_q + INDEX_W'(1);
  assign cnt_en   = (state_q == SHOW) & ~hold;

  scroll_prescaler #(
    .TICKS_PER_BYTE(TICKS_PER_BYTE),
    .CNT_W         (CNT_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .clear (load_acc),
    .enable(cnt_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (load_acc) state_d = SHOW;
      SHOW: begin
`ifndef AES_SCROLL_LOOP_EN
        if (!load_acc && tick && last) state_d = DONE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // byte_out is registered from the captured block, never from data_in directly
  always_comb begin
    idx_d  = idx_q;
    byte_d = byte_q;
    if (load_acc) begin
      idx_d  = '0;
      byte_d = block_byte(data_in, '0);
    end else if (tick && !last) begin
      idx_d  = idx_nx;
      byte_d = block_byte(data_q, idx_nx);
`ifdef AES_SCROLL_LOOP_EN
    end else if (tick && last) begin
      idx_d  = '0;
      byte_d = block_byte(data_q, '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      idx_q  <= '0;
      byte_q <= '0;
    end else begin
      if (load_acc) data_q <= data_in;
      idx_q  <= idx_d;
      byte_q <= byte_d;
    end
  end

`ifdef AES_SCROLL_LOOP_EN
  logic done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= !load_acc && tick && last;
  end

  always_comb begin
    ready = 1'b1;
    busy  = (state_q == SHOW);
    done  = done_q;
  end
`else
  always_comb begin
    ready = (state_q != SHOW);
    busy  = (state_q == SHOW);
    done  = (state_q == DONE);
  end
`endif

  assign byte_out = byte_q;
  assign index    = idx_q;

endmodule

// File: tb/tb_aes_result_scroller.sv
// Bench for aes_result_scroller: two instances (4 and 1 cycles per byte) against an elapsed-time model.
module tb_aes_result_scroller;

`ifdef AES_SCROLL_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, load, hold;
  logic [127:0] data;
  logic         rdy [2];
  logic         bsy [2];
  logic         dn  [2];
  logic [7:0]   bo  [2];
  logic [3:0]   ix  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_result_scroller #(.TICKS_PER_BYTE(4), .CNT_W(3)) u4 (
    .clk(clk), .reset(rst_n), .load(load), .data_in(data), .hold(hold),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .byte_out(bo[0]), .index(ix[0])
  );

  aes_result_scroller #(.TICKS_PER_BYTE(1), .CNT_W(1)) u1 (
    .clk(clk), .reset(rst_n), .load(load), .data_in(data), .hold(hold),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .byte_out(bo[1]), .index(ix[1])
  );

  function automatic int tk(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] bsel(input logic [127:0] b, input int k);
    logic [127:0] s;
    s = b >> (8 * (15 - k));
    return s[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: elapsed un-held cycles since the accepted load decide everything.
  bit           m_ld  [2] = '{0, 0};
  longint       m_t   [2] = '{0, 0};
  logic [127:0] m_blk [2] = '{128'h0, 128'h0};
  bit           m_pl  [2] = '{0, 0};

  function automatic bit m_ready(input int i);
    return !m_ld[i] || LOOP || (m_t[i] >= 16 * tk(i));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ld[i] <= 1'b0; m_t[i] <= 0; m_pl[i] <= 1'b0; m_blk[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load && m_ready(i)) begin
          m_blk[i] <= data; m_t[i] <= 0; m_ld[i] <= 1'b1; m_pl[i] <= 1'b0;
        end else if (m_ld[i] && !hold && (LOOP || m_t[i] < 16 * tk(i))) begin
          m_t[i]  <= m_t[i] + 1;
          m_pl[i] <= LOOP && (((m_t[i] + 1) % (16 * tk(i))) == 0);
        end else begin
          m_pl[i] <= 1'b0;
        end
      end
    end
  end

  logic [7:0] e_b;
  logic [3:0] e_i;
  bit         e_r, e_u, e_d;
  int         e_k;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_k = 0; e_r = 1'b1; e_u = 1'b0; e_d = 1'b0;
      if (!m_ld[i]) begin
        e_b = 8'h00;
      end else begin
        if (LOOP) begin
          e_k = int'((m_t[i] / tk(i)) % 16); e_u = 1'b1; e_d = m_pl[i];
        end else if (m_t[i] < 16 * tk(i)) begin
          e_k = int'(m_t[i] / tk(i)); e_r = 1'b0; e_u = 1'b1;
        end else begin
          e_k = 15; e_d = 1'b1;
        end
        e_b = bsel(m_blk[i], e_k);
      end
      e_i = 4'(e_k);
      chk($sformatf("model_byte[%0d]", i),  32'(bo[i]),  32'(e_b));
      chk($sformatf("model_index[%0d]", i), 32'(ix[i]),  32'(e_i));
      chk($sformatf("model_ready[%0d]", i), 32'(rdy[i]), 32'(e_r));
      chk($sformatf("model_busy[%0d]", i),  32'(bsy[i]), 32'(e_u));
      chk($sformatf("model_done[%0d]", i),  32'(dn[i]),  32'(e_d));
    end
  end

  localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_B = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

  initial begin
    rst_n = 1'b0; load = 1'b0; hold = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_idle_ready", 32'(rdy[0]), 32'd1);
    chk("lit_idle_byte", 32'(bo[0]), 32'h00);

    // first block, k = cycles since the load edge
    data = BLK_A; load = 1'b1;
    @(negedge clk); load = 1'b0; data = '0;
    chk("lit_k1_byte4", 32'(bo[0]), 32'h00);
    chk("lit_k1_busy4", 32'(bsy[0]), 32'd1);
    chk("lit_k1_byte1", 32'(bo[1]), 32'h00);
    repeat (3) @(negedge clk);
    chk("lit_k4_byte4", 32'(bo[0]), 32'h00);
    chk("lit_k4_byte1", 32'(bo[1]), 32'h33);
    @(negedge clk);
    chk("lit_k5_byte4", 32'(bo[0]), 32'h11);
    chk("lit_k5_idx4", 32'(ix[0]), 32'd1);
    repeat (8) @(negedge clk);
    chk("lit_k13_idx4", 32'(ix[0]), 32'd3);
`ifndef AES_SCROLL_LOOP_EN
    data = BLK_B; load = 1'b1;
    @(negedge clk); load = 1'b0; data = '0;
    chk("lit_busy_load_ignored", 32'(bo[0]), 32'h33);
`else
    @(negedge clk);
`endif
    repeat (2) @(negedge clk);
    chk("lit_t1_last_byte", 32'(bo[1]), 32'hff);
    chk("lit_t1_last_idx", 32'(ix[1]), 32'd15);
    @(negedge clk);
    chk("lit_t1_done", 32'(dn[1]), 32'd1);
    repeat (47) @(negedge clk);
    chk("lit_k64_byte", 32'(bo[0]), 32'hff);
    chk("lit_k64_busy", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    chk("lit_k65_done", 32'(dn[0]), 32'd1);
`ifndef AES_SCROLL_LOOP_EN
    chk("lit_k65_byte", 32'(bo[0]), 32'hff);
    chk("lit_k65_idx", 32'(ix[0]), 32'd15);
    chk("lit_k65_busy", 32'(bsy[0]), 32'd0);
`else
    chk("lit_k65_wrap_byte", 32'(bo[0]), 32'h00);
    chk("lit_k65_wrap_idx", 32'(ix[0]), 32'd0);
`endif

    // restart with a new block (from DONE, or mid-loop)
    data = BLK_B; load = 1'b1;
    @(negedge clk); load = 1'b0; data = '0;
    chk("lit_reload_done", 32'(dn[0]), 32'd0);
    chk("lit_reload_byte", 32'(bo[0]), 32'hf0);
    chk("lit_reload_idx", 32'(ix[0]), 32'd0);
    repeat (22) @(negedge clk);
    chk("lit_pre_hold_byte", 32'(bo[0]), 32'ha5);
    hold = 1'b1;
    repeat (10) @(negedge clk);
    chk("lit_hold_byte", 32'(bo[0]), 32'ha5);
    chk("lit_hold_idx", 32'(ix[0]), 32'd5);
    hold = 1'b0;
    @(negedge clk);
    chk("lit_release_idx5", 32'(ix[0]), 32'd5);
    @(negedge clk);
    chk("lit_release_idx6", 32'(ix[0]), 32'd6);
    chk("lit_release_byte", 32'(bo[0]), 32'h96);
    repeat (40) @(negedge clk);

    // load and hold together: load wins, counting waits for hold to drop
    data = BLK_A; load = 1'b1; hold = 1'b1;
    @(negedge clk); load = 1'b0; data = '0;
    repeat (4) @(negedge clk);
    chk("lit_lh_idx", 32'(ix[0]), 32'd0);
    chk("lit_lh_byte", 32'(bo[0]), 32'h00);
    hold = 1'b0;
    repeat (4) @(negedge clk);
    chk("lit_lh_resume", 32'(bo[0]), 32'h11);
    repeat (24) @(negedge clk);
    chk("lit_idx7", 32'(ix[0]), 32'd7);

    // asynchronous reset mid-scroll
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_idx", 32'(ix[0]), 32'd0);
    chk("lit_rst_byte", 32'(bo[0]), 32'h00);
    chk("lit_rst_busy", 32'(bsy[0]), 32'd0);
    chk("lit_rst_done", 32'(dn[0]), 32'd0);
    chk("lit_rst_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(0, 39) == 0);
      hold = ($urandom_range(0, 7) == 0);
      data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    load = 1'b0; hold = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
